// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multi-cycle RV32I-subset control unit:
//   - opcode constants of the supported instruction classes
//   - ALU operation codes (AND/OR/ADD/SUB)
//   - controller state enum (encoding is visible on state_dbg)
//   - trap cause codes
//   - opcode_is_legal(): legality check used by DECODE
// Optional feature macro: CTRL_ITYPE_EN (makes OP-IMM, opcode 0x13, legal).
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_ITYPE  = 7'h13;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // True for every opcode this controller can sequence.
    function automatic logic opcode_is_legal(input logic [6:0] opc);
        logic legal;
        legal = 1'b0;
        case (opc)
            OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH: legal = 1'b1;
`ifdef CTRL_ITYPE_EN
            OPC_ITYPE:                                  legal = 1'b1;
`endif
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// ---------------------------------------------------------------------------
// ctrl_alu_decode
// Combinational mapping of the latched instruction fields to the ALU
// operation and the B-operand select. Kept standalone so the pipelined
// decoder can reuse it.
// Ports:
//   opcode  in  7  latched opcode
//   func3   in  3  latched func3
//   bit30   in  1  latched instruction bit 30 (SUB select for R-type)
//   alu_op  out 4  ALU operation code
//   alu_src out 1  1 = B operand is the immediate
// Optional feature macro: CTRL_ITYPE_EN (decodes OP-IMM, opcode 0x13).
// ---------------------------------------------------------------------------
module ctrl_alu_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       bit30,
    output logic [3:0] alu_op,
    output logic       alu_src
);

    // Register/immediate arithmetic share one func3 map; only func3=0 can
    // become SUB, and only when the caller allows it.
    function automatic logic [3:0] arith_map(input logic [2:0] f3, input logic sub_sel);
        logic [3:0] op;
        case (f3)
            3'd0:    op = sub_sel ? ALU_SUB : ALU_ADD;
            3'd7:    op = ALU_AND;
            3'd6:    op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Opcode class -> ALU operation and operand select.
    always_comb begin
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                alu_op  = arith_map(func3, bit30);
                alu_src = 1'b0;
            end
`ifdef CTRL_ITYPE_EN
            OPC_ITYPE: begin
                // bit30 is part of the immediate here, never a SUB select
                alu_op  = arith_map(func3, 1'b0);
                alu_src = 1'b1;
            end
`endif
            OPC_LOAD, OPC_STORE: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
            end
            OPC_BRANCH: begin
                alu_op  = ALU_SUB;
                alu_src = 1'b0;
            end
            default: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controll.sv
// ---------------------------------------------------------------------------
// multicycle_controll
// Multi-cycle main control for the RV32I-subset core. Sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB with a req/ready memory
// handshake, latches opcode/func3/bit30 once per instruction in DECODE,
// guards every memory wait with a watchdog and parks in a sticky TRAP state
// on an illegal opcode or a memory timeout.
// Parameters:
//   ALU_OP_W     width of ALU_op
//   MEM_TIMEOUT  max cycles waiting for mem_ready in FETCH/MEM (0 = off)
//   TO_W         watchdog counter width (derived)
// Ports:
//   clk, rst_n (synchronous, active low)
//   instruction  IR contents, sampled only in DECODE
//   mem_ready    memory completes the current access
//   mem_req, mem_we, mem_is_instr, ir_write, pc_write   memory/datapath
//   branch, MemRead, MemtoReg, MemWrite, ALUScr, RegWrite, ALU_op  control
//   trap, trap_cause, state_dbg                          status/debug
// Optional feature macro: CTRL_ITYPE_EN (OP-IMM, opcode 0x13, becomes legal).
// ---------------------------------------------------------------------------
module multicycle_controll
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instruction,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_is_instr,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                MemRead,
    output logic                MemtoReg,
    output logic                MemWrite,
    output logic                ALUScr,
    output logic                RegWrite,
    output logic [ALU_OP_W-1:0] ALU_op,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state_dbg
);

    localparam bit             WDOG_EN = (MEM_TIMEOUT > 0);
    // Count value of the last waiting cycle allowed before the trap.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          state_q,  state_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      func3_q,  func3_d;
    logic            bit30_q,  bit30_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]      cause_q,  cause_d;

    logic            is_load_s;
    logic            is_store_s;
    logic            is_branch_s;
    logic            wdog_hit_s;
    logic [3:0]      dec_alu_op_s;
    logic            dec_alu_src_s;
    logic            unused_instr_s;

    assign is_load_s   = (opcode_q == OPC_LOAD);
    assign is_store_s  = (opcode_q == OPC_STORE);
    assign is_branch_s = (opcode_q == OPC_BRANCH);
    assign wdog_hit_s  = WDOG_EN && (to_cnt_q == TO_LAST);
    assign state_dbg   = state_q;

    // Only opcode, func3 and bit30 steer control; the rest of the IR is data.
    assign unused_instr_s = ^{instruction[31], instruction[29:15], instruction[11:7]};

    ctrl_alu_decode u_alu_decode (
        .opcode  (opcode_q),
        .func3   (func3_q),
        .bit30   (bit30_q),
        .alu_op  (dec_alu_op_s),
        .alu_src (dec_alu_src_s)
    );

    // State register, latched fields, watchdog counter and trap cause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= 7'd0;
            func3_q  <= 3'd0;
            bit30_q  <= 1'b0;
            to_cnt_q <= {TO_W{1'b0}};
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            func3_q  <= func3_d;
            bit30_q  <= bit30_d;
            to_cnt_q <= to_cnt_d;
            cause_q  <= cause_d;
        end
    end

    // Next-state logic. The watchdog count defaults to zero so it is clear on
    // every entry into FETCH/MEM and only grows while a wait is in progress.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        func3_d  = func3_q;
        bit30_d  = bit30_q;
        to_cnt_d = {TO_W{1'b0}};
        cause_d  = cause_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // mem_ready takes priority over an expiring watchdog
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wdog_hit_s) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_DECODE: begin
                opcode_d = instruction[6:0];
                func3_d  = instruction[14:12];
                bit30_d  = instruction[30];
                if (opcode_is_legal(instruction[6:0])) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (is_load_s || is_store_s) begin
                    state_d = ST_MEM;
                end else if (is_branch_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = is_load_s ? ST_WB : ST_FETCH;
                end else if (wdog_hit_s) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state register and latched fields. ir_write and
    // pc_write additionally qualify on mem_ready to mark the fetch-complete cycle.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_instr = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        MemRead      = 1'b0;
        MemtoReg     = 1'b0;
        MemWrite     = 1'b0;
        ALUScr       = 1'b0;
        RegWrite     = 1'b0;
        ALU_op       = {ALU_OP_W{1'b0}};
        trap         = 1'b0;
        trap_cause   = CAUSE_NONE;
        case (state_q)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_is_instr = 1'b1;
                ir_write     = mem_ready;
                pc_write     = mem_ready;
            end
            ST_EXEC: begin
                ALU_op = ALU_OP_W'(dec_alu_op_s);
                ALUScr = dec_alu_src_s;
                branch = is_branch_s;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                MemRead  = is_load_s;
                MemWrite = is_store_s;
                mem_we   = is_store_s;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = is_load_s;
            end
            ST_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controll.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controll
// Randomized bench for multicycle_controll (MEM_TIMEOUT=4). Each instruction
// is expanded by a transaction-level model into the list of cycles it must
// take (fetch waits, decode, exec, memory waits, writeback, trap) together
// with the expected output vector of every cycle; the bench then replays the
// list, driving mem_ready/instruction and comparing all outputs each cycle.
// Follows CTRL_ITYPE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_multicycle_controll;

    localparam int TO = 4;

    localparam logic [3:0] A_AND = 4'h0;
    localparam logic [3:0] A_OR  = 4'h1;
    localparam logic [3:0] A_ADD = 4'h2;
    localparam logic [3:0] A_SUB = 4'h6;

`ifdef CTRL_ITYPE_EN
    localparam bit ITYPE_ON = 1'b1;
`else
    localparam bit ITYPE_ON = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       mem_is_instr;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu;
        logic       trap;
        logic [1:0] cause;
    } outs_t;

    typedef struct {
        logic        ready;
        logic [31:0] ins;
        outs_t       exp;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] instruction = 32'd0;

    logic       mem_req, mem_we, mem_is_instr, ir_write, pc_write, branch;
    logic       MemRead, MemtoReg, MemWrite, ALUScr, RegWrite, trap;
    logic [3:0] ALU_op;
    logic [1:0] trap_cause;
    logic [2:0] state_dbg;

    outs_t dut_o;
    assign dut_o = {state_dbg, mem_req, mem_we, mem_is_instr, ir_write, pc_write,
                    branch, MemRead, MemtoReg, MemWrite, ALUScr, RegWrite,
                    ALU_op, trap, trap_cause};

    multicycle_controll #(
        .ALU_OP_W    (4),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_is_instr (mem_is_instr),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .branch       (branch),
        .MemRead      (MemRead),
        .MemtoReg     (MemtoReg),
        .MemWrite     (MemWrite),
        .ALUScr       (ALUScr),
        .RegWrite     (RegWrite),
        .ALU_op       (ALU_op),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    cyc_t q[$];
    bit   trapped;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
    endtask

    function automatic string st_name(input logic [2:0] st);
        case (st)
            3'd0:    return "idle";
            3'd1:    return "fetch";
            3'd2:    return "decode";
            3'd3:    return "exec";
            3'd4:    return "mem";
            3'd5:    return "wb";
            3'd6:    return "trap";
            default: return "bad";
        endcase
    endfunction

    function automatic outs_t o_base(input logic [2:0] st);
        outs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic bit legal(input logic [6:0] opc);
        return (opc == 7'h33) || (opc == 7'h03) || (opc == 7'h23) || (opc == 7'h63) ||
               (ITYPE_ON && (opc == 7'h13));
    endfunction

    function automatic logic [3:0] exp_alu(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
        if (opc == 7'h63) return A_SUB;
        if (opc == 7'h03 || opc == 7'h23) return A_ADD;
        if (f3 == 3'd7) return A_AND;
        if (f3 == 3'd6) return A_OR;
        if (f3 == 3'd0 && opc == 7'h33 && b30) return A_SUB;
        return A_ADD;
    endfunction

    task automatic push(input logic rdy, input logic [31:0] ins, input outs_t o);
        cyc_t c;
        c.ready = rdy;
        c.ins   = ins;
        c.exp   = o;
        q.push_back(c);
    endtask

    // A memory wait of 'waits' idle cycles; TO or more idle cycles expire.
    task automatic wait_phase(input int waits, input outs_t busy, input outs_t done, output bit timed_out);
        timed_out = (waits >= TO);
        for (int i = 0; i < ((waits >= TO) ? TO : waits); i++) push(1'b0, $urandom, busy);
        if (!timed_out) push(1'b1, $urandom, done);
    endtask

    task automatic push_trap(input logic [1:0] cause);
        outs_t o;
        o       = o_base(3'd6);
        o.trap  = 1'b1;
        o.cause = cause;
        for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), $urandom, o);
        trapped = 1'b1;
    endtask

    // Expand one instruction into its expected cycle sequence.
    task automatic build(input logic [31:0] ins, input int fw, input int mw);
        logic [6:0] opc;
        outs_t      f, fr, e, m, w;
        bit         to;
        opc = ins[6:0];
        f = o_base(3'd1);
        f.mem_req = 1'b1;
        f.mem_is_instr = 1'b1;
        fr = f;
        fr.ir_write = 1'b1;
        fr.pc_write = 1'b1;
        wait_phase(fw, f, fr, to);
        if (to) begin
            push_trap(2'b10);
            return;
        end
        push(1'($urandom_range(0, 1)), ins, o_base(3'd2));
        if (!legal(opc)) begin
            push_trap(2'b01);
            return;
        end
        e = o_base(3'd3);
        e.alu     = exp_alu(opc, ins[14:12], ins[30]);
        e.alu_src = (opc == 7'h03) || (opc == 7'h23) || (opc == 7'h13);
        e.branch  = (opc == 7'h63);
        push(1'($urandom_range(0, 1)), $urandom, e);
        if (opc == 7'h63) return;
        if (opc == 7'h03 || opc == 7'h23) begin
            m = o_base(3'd4);
            m.mem_req   = 1'b1;
            m.mem_read  = (opc == 7'h03);
            m.mem_write = (opc == 7'h23);
            m.mem_we    = (opc == 7'h23);
            wait_phase(mw, m, m, to);
            if (to) begin
                push_trap(2'b10);
                return;
            end
            if (opc == 7'h23) return;
        end
        w = o_base(3'd5);
        w.reg_write  = 1'b1;
        w.mem_to_reg = (opc == 7'h03);
        push(1'($urandom_range(0, 1)), $urandom, w);
    endtask

    task automatic play(input int cut);
        for (int i = 0; i < cut; i++) begin
            @(negedge clk);
            mem_ready   = q[i].ready;
            instruction = q[i].ins;
            #1;
            check_eq($sformatf("%s#%0d", st_name(q[i].exp.st), i), 32'(dut_o), 32'(q[i].exp));
        end
    endtask

    // Two reset cycles; IDLE with all outputs low while held and on release.
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        mem_ready   = 1'($urandom_range(0, 1));
        instruction = $urandom;
        @(negedge clk);
        #1;
        check_eq("reset_idle", 32'(dut_o), 32'(o_base(3'd0)));
        @(negedge clk);
        #1;
        check_eq("reset_hold", 32'(dut_o), 32'(o_base(3'd0)));
        rst_n = 1'b1;
    endtask

    // abort: -1 none, -2 reset right after the first MEM cycle, else cycle index
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int abort);
        int cut;
        q.delete();
        trapped = 1'b0;
        build(ins, fw, mw);
        cut = q.size();
        if (abort == -2) begin
            for (int i = 0; i < q.size(); i++)
                if (q[i].exp.st == 3'd4 && cut == q.size()) cut = i + 1;
        end else if (abort >= 0 && abort < q.size()) begin
            cut = abort;
        end
        play(cut);
        if (trapped || cut < q.size()) do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] ins;
        int          sel, fw, mw, ab;

        do_reset();
        run_instr(32'h4000_00B3, 0, 0, -1);   // SUB R-type
        run_instr(32'h0000_2083, 0, 3, -1);   // load, 3 wait cycles in MEM
        run_instr(32'h0020_A023, 0, 0, -1);   // store
        run_instr(32'h0020_8063, 0, 0, -1);   // branch
        run_instr(32'h0000_707F, 0, 0, -1);   // illegal opcode 0x7F
        run_instr(32'h0000_6033, 4, 0, -1);   // fetch timeout
        run_instr(32'h0000_7033, 3, 0, -1);   // ready on the 4th wait cycle
        run_instr(32'h0000_2003, 0, 3, -1);   // ready on the 4th MEM cycle
        run_instr(32'h0000_2003, 0, 7, -1);   // MEM timeout
        run_instr(32'h0000_2003, 0, 2, -2);   // reset mid-MEM
        run_instr(32'h4000_0013, 1, 0, -1);   // OP-IMM, bit30 set

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    ins[6:0] = 7'h33;
                2, 8:    ins[6:0] = 7'h03;
                3, 9:    ins[6:0] = 7'h23;
                4:       ins[6:0] = 7'h63;
                5:       ins[6:0] = 7'h13;
                6:       ins[6:0] = 7'h7F;
                default: ins[6:0] = 7'($urandom);
            endcase
            fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
            mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
            ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 8) : -1;
            run_instr(ins, fw, mw, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
